sonuc_bcd_cevirici: RTL
=======================

SONUC_BCD_CEVIRICI -- requirements
Module: sonuc_bcd_cevirici

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk is the clock; rst is sampled on the rising edge of clk and is active high.
REQ-002 The block SHALL have port clk: input, 1 bit, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst: input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port sonuc: input, 64 bits, binary result from the calculator stage.
REQ-005 The block SHALL have port hazir: input, 1 bit, upstream result-ready; a 0->1 transition marks a new result.
REQ-006 The block SHALL have port gecerli: input, 1 bit, upstream result-valid flag.
REQ-007 The block SHALL have port tasma: input, 1 bit, upstream overflow flag.
REQ-008 The block SHALL have port bcd: output, 80 bits, 20 packed BCD digits; bits [3:0] are the least significant digit.
REQ-009 The block SHALL have port isaret: output, 1 bit, sign of the displayed value (1 = negative).
REQ-010 The block SHALL have port bcd_hazir: output, 1 bit, one-cycle pulse marking a new bcd/hata value.
REQ-011 The block SHALL have port hata: output, 1 bit, the last accepted result was invalid or overflowed.
REQ-012 The block SHALL have port mesgul: output, 1 bit, high while a result is being processed.

Function
REQ-013 The block SHALL implement three states, BOS, CEVIR and BITTI, and SHALL register hazir internally (hazir_q) for edge detection.
REQ-014 In BOS, when hazir=1 and hazir_q=0, the block SHALL latch sonuc, gecerli and tasma, assert mesgul, and leave BOS (capture edge E0).
REQ-015 If the latched gecerli=0 or tasma=1, the block SHALL go from BOS to BITTI, skipping conversion, with hata=1, bcd=0 and isaret=0.
REQ-016 Otherwise the block SHALL enter CEVIR and run exactly 64 double-dabble iterations, one per clock: add 3 to each digit >=5, then shift one binary bit in, MSB first.
REQ-017 The iteration counter SHALL be 7 bits, count 0..63, and SHALL NOT wrap; after iteration 63 the state SHALL become BITTI.
REQ-018 In BITTI, for exactly one cycle, the block SHALL update bcd, isaret and hata from the internal registers, pulse bcd_hazir=1, and return to BOS with mesgul=0.
REQ-019 Valid-path latency SHALL be: bcd_hazir high after the 65th rising edge following E0.
REQ-020 Error-path latency SHALL be: bcd_hazir high after the 1st rising edge following E0.
REQ-021 bcd, isaret and hata SHALL hold their last values between bcd_hazir pulses and SHALL NOT change during CEVIR.
REQ-022 hazir edges that occur while not in BOS SHALL be ignored and SHALL NOT be queued.
REQ-023 A hazir edge in the same cycle that BITTI returns to BOS SHALL be ignored, because the capture decision is made only in state BOS.
REQ-024 In unsigned mode, the conversion input SHALL be sonuc taken as an unsigned 64-bit value; the maximum 18446744073709551615 SHALL fit in 20 digits.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL go to BOS with bcd=0, isaret=0, hata=0, bcd_hazir=0, mesgul=0, hazir_q=0 and the counter at 0.
REQ-026 rst SHALL take priority over every other condition, including mid-CEVIR; a conversion in progress SHALL be discarded and SHALL produce no bcd_hazir.
REQ-027 If hazir=1 at the first edge after reset release, that level SHALL count as a 0->1 edge and SHALL be captured.

Configuration
REQ-028 When macro ISARET_DESTEK_EN is defined: if the latched sonuc[63]=1, the block SHALL convert the two's-complement magnitude (~sonuc+1) and set isaret=1 in BITTI; otherwise isaret=0.
REQ-029 When ISARET_DESTEK_EN is defined, 0x8000_0000_0000_0000 SHALL give magnitude 9223372036854775808 with isaret=1.
REQ-030 Without ISARET_DESTEK_EN, sonuc SHALL be treated as unsigned, isaret SHALL be tied to 0, and no negation logic SHALL exist.

Verification
REQ-031 A bench SHALL cover: sonuc=0, gecerli=1, tasma=0, hazir 0->1 -> bcd=0, hata=0, bcd_hazir pulse 65 edges after capture, mesgul high throughout.
REQ-032 A bench SHALL cover: sonuc=12345 -> bcd low 20 bits = 0x12345, upper digits 0, isaret=0.
REQ-033 A bench SHALL cover: sonuc=0xFFFF_FFFF_FFFF_FFFF -> unsigned build: bcd=0x18446744073709551615, isaret=0; ISARET_DESTEK_EN build: bcd=1, isaret=1.
REQ-034 A bench SHALL cover: tasma=1 (or gecerli=0), sonuc=999 -> hata=1, bcd=0, bcd_hazir 1 edge after capture.
REQ-035 A bench SHALL cover: rst=1 at iteration 30 of a conversion of 777 -> all outputs 0, no bcd_hazir; the next hazir edge with 42 -> bcd=0x42 after 65 edges.
REQ-036 A bench SHALL cover: second hazir edge with sonuc=5 at iteration 10 of a conversion of 100 -> only bcd=0x100 is reported; the second edge is dropped.

Source files
------------

// File: rtl/sonuc_bcd_cevirici_if.sv
`default_nettype none
// ============================================================================
// Module   : sonuc_bcd_cevirici_if
// Brief    : Result-in / BCD-out bus between the calculator stage and the
//            binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
interface sonuc_bcd_cevirici_if;
    logic [63:0] sonuc;
    logic        hazir;
    logic        gecerli;
    logic        tasma;
    logic [79:0] bcd;
    logic        isaret;
    logic        bcd_hazir;
    logic        hata;
    logic        mesgul;

    modport master (
        output sonuc, hazir, gecerli, tasma,
        input  bcd, isaret, bcd_hazir, hata, mesgul
    );

    modport slave (
        input  sonuc, hazir, gecerli, tasma,
        output bcd, isaret, bcd_hazir, hata, mesgul
    );
endinterface
`default_nettype wire

// File: rtl/sonuc_bcd_cevirici.sv
`default_nettype none
// ============================================================================
// Module   : sonuc_bcd_cevirici
// Brief    : Sequential 64-bit binary to 20-digit BCD converter (double dabble,
//            one bit per clock). Optional macro ISARET_DESTEK_EN enables
//            two's-complement input with sign output.
// Revision : 1.0 - initial release
// ============================================================================
module sonuc_bcd_cevirici (
    input  wire logic            clk,
    input  wire logic            rst,
    sonuc_bcd_cevirici_if.slave  bus
);
    localparam int C_DIGITS = 20;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        CEVIR = 2'd1,
        BITTI = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_hazir_q;
    logic [6:0]  r_sayac;
    logic [63:0] r_bin;
    logic [79:0] r_bcd_work;
    logic        r_hata_work;
    logic [79:0] r_bcd;
    logic        r_hata;
    logic        r_bcd_hazir;

    logic        w_yakala;
    logic        w_hata_in;
    logic [63:0] w_buyukluk;
    logic [79:0] w_adj;
    logic [79:0] w_shift;

    // Capture only from BOS, so edges during CEVIR/BITTI are simply lost
    assign w_yakala  = (r_state == BOS) && bus.hazir && !r_hazir_q;
    assign w_hata_in = !bus.gecerli || bus.tasma;

`ifdef ISARET_DESTEK_EN
    logic r_isaret_work;
    logic r_isaret;
    assign w_buyukluk = bus.sonuc[63] ? (~bus.sonuc + 64'd1) : bus.sonuc;
    assign bus.isaret = r_isaret;
`else
    assign w_buyukluk = bus.sonuc;
    assign bus.isaret = 1'b0;
`endif

    for (genvar i = 0; i < C_DIGITS; i++) begin : g_digit
        assign w_adj[4*i +: 4] = (r_bcd_work[4*i +: 4] >= 4'd5) ?
                                 (r_bcd_work[4*i +: 4] + 4'd3) :
                                 r_bcd_work[4*i +: 4];
    end

    assign w_shift = {w_adj[78:0], r_bin[63]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOS:     if (w_yakala) w_state_next = w_hata_in ? BITTI : CEVIR;
            CEVIR:   if (r_sayac == 7'd63) w_state_next = BITTI;
            BITTI:   w_state_next = BOS;
            default: w_state_next = BOS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOS;
            r_hazir_q     <= 1'b0;
            r_sayac       <= 7'd0;
            r_bin         <= '0;
            r_bcd_work    <= '0;
            r_hata_work   <= 1'b0;
            r_bcd         <= '0;
            r_hata        <= 1'b0;
            r_bcd_hazir   <= 1'b0;
`ifdef ISARET_DESTEK_EN
            r_isaret_work <= 1'b0;
            r_isaret      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_hazir_q   <= bus.hazir;
            r_bcd_hazir <= 1'b0;
            case (r_state)
                BOS: begin
                    if (w_yakala) begin
                        r_bin         <= w_buyukluk;
                        r_bcd_work    <= '0;
                        r_hata_work   <= w_hata_in;
                        r_sayac       <= 7'd0;
`ifdef ISARET_DESTEK_EN
                        r_isaret_work <= bus.sonuc[63] && !w_hata_in;
`endif
                    end
                end
                CEVIR: begin
                    r_bcd_work <= w_shift;
                    r_bin      <= {r_bin[62:0], 1'b0};
                    // Saturates at 63; the state change ends the run
                    if (r_sayac != 7'd63) r_sayac <= r_sayac + 7'd1;
                end
                BITTI: begin
                    r_bcd       <= r_hata_work ? '0 : r_bcd_work;
                    r_hata      <= r_hata_work;
                    r_bcd_hazir <= 1'b1;
                    r_sayac     <= 7'd0;
`ifdef ISARET_DESTEK_EN
                    r_isaret    <= r_isaret_work && !r_hata_work;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd       = r_bcd;
    assign bus.hata      = r_hata;
    assign bus.bcd_hazir = r_bcd_hazir;
    assign bus.mesgul    = (r_state != BOS);

endmodule
`default_nettype wire
